gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank.sv | 134 +++++++++++++
 tb/tb_gpio_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// Bank of NPORTS 8-bit GPIO ports with CPU register access, synchronised pad
// inputs, per-bit edge flags and a single registered level interrupt.
module gpio_port #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  OUT_RESET   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [2:0] reg_sel,
  input  logic [7:0] din,
  input  logic [7:0] pad,
  output logic [7:0] out,
  output logic [7:0] dir,
  output logic [7:0] rdata,
  output logic [7:0] pend
);
  logic [SYNC_STAGES-1:0][7:0] sync;
  logic [7:0] pin, dly, rise, fall, evt, clr;
  logic [7:0] out_q, dir_q, ie_q, edge_q, both_q, flag_q;

  assign pin  = sync[SYNC_STAGES-1];
  assign rise = pin & ~dly;
  assign fall = ~pin & dly;
  assign evt  = (both_q & (rise | fall)) | (~both_q & ((edge_q & fall) | (~edge_q & rise)));
  assign clr  = (wr && reg_sel == 3'd6) ? din : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      dly  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
      dly  <= pin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= OUT_RESET;
      dir_q  <= '0;
      ie_q   <= '0;
      edge_q <= '0;
      both_q <= '0;
      flag_q <= '0;
    end else begin
      // a new event on a bit beats a simultaneous write-1-to-clear of that bit
      flag_q <= (flag_q & ~clr) | evt;
      if (wr) begin
        case (reg_sel)
          3'd0: out_q  <= din;
          3'd1: dir_q  <= din;
          3'd3: ie_q   <= din;
          3'd4: edge_q <= din;
          3'd5: both_q <= din;
          3'd7: out_q  <= din[7] ? (out_q | {1'b0, din[6:0]}) : (out_q & ~{1'b0, din[6:0]});
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      3'd0: rdata = out_q;
      3'd1: rdata = dir_q;
      3'd2: rdata = pin;
      3'd3: rdata = ie_q;
      3'd4: rdata = edge_q;
      3'd5: rdata = both_q;
      3'd6: rdata = flag_q;
      default: rdata = 8'h00;
    endcase
  end

  assign out  = out_q;
  assign dir  = dir_q;
  assign pend = flag_q & ie_q;
endmodule

module gpio_bank #(
  parameter int         NPORTS      = 2,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] OUT_RESET   = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic [4:0]            addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  input  logic [8*NPORTS-1:0]   gpio_i,
  output logic [8*NPORTS-1:0]   gpio_o,
  output logic [8*NPORTS-1:0]   gpio_oe,
  output logic                  irq
);
  // Arrays span the full 2-bit port index so absent ports read back as zero.
  logic [3:0][7:0] rdata;
  logic [3:0][7:0] pend;

  for (genvar p = 0; p < 4; p++) begin : g_port
    if (p < NPORTS) begin : g_on
      logic wr;
      assign wr = cs & we & (addr[4:3] == 2'(p));
      gpio_port #(.SYNC_STAGES(SYNC_STAGES), .OUT_RESET(OUT_RESET)) u_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr),
        .reg_sel (addr[2:0]),
        .din     (din),
        .pad     (gpio_i[8*p +: 8]),
        .out     (gpio_o[8*p +: 8]),
        .dir     (gpio_oe[8*p +: 8]),
        .rdata   (rdata[p]),
        .pend    (pend[p])
      );
    end else begin : g_off
      assign rdata[p] = 8'h00;
      assign pend[p]  = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= 8'h00;
      irq  <= 1'b0;
    end else begin
      irq <= |pend;
      if (cs && !we) dout <= rdata[addr[4:3]];
    end
  end
endmodule

// File: tb/tb_gpio_bank.sv
// Randomised + directed scoreboard bench for gpio_bank against a history-based model.
module tb_gpio_bank;
  localparam int         NP   = 2;
  localparam int         S    = 2;
  localparam logic [7:0] ORST = 8'h5A;

  logic clk = 1'b0;
  logic rst_n, cs, we;
  logic [4:0] addr;
  logic [7:0] din, dout;
  logic [8*NP-1:0] gpio_i, gpio_o, gpio_oe;
  logic irq;

  always #5 clk = ~clk;

  gpio_bank #(.NPORTS(NP), .SYNC_STAGES(S), .OUT_RESET(ORST)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  typedef struct {
    logic [7:0]      dout;
    logic [8*NP-1:0] o;
    logic [8*NP-1:0] oe;
    logic            irq;
    int              cyc;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0, n_fail = 0, ncyc = 0;

  // Reference state: registers per port, plus the history of sampled pad values.
  // hist[i] is the pad value sampled i edges ago; the CPU sees hist[S] as PIN.
  logic [7:0] m_out[NP], m_dir[NP], m_ie[NP], m_edge[NP], m_both[NP], m_flag[NP];
  logic [7:0] m_dout;
  logic       m_irq;
  logic [8*NP-1:0] hist[$];
  logic [8*NP-1:0] pad_v;

  task automatic model_step();
    logic [8*NP-1:0] cur, prv;
    logic [7:0] rv, evt;
    logic irq_n, a, z;
    int pt;
    exp_t e;
    ncyc++;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        m_out[p] = ORST; m_dir[p] = 0; m_ie[p] = 0; m_edge[p] = 0; m_both[p] = 0; m_flag[p] = 0;
      end
      m_dout = 0; m_irq = 0;
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back('0);
    end else begin
      hist.push_front(gpio_i);
      void'(hist.pop_back());
      cur = hist[S];
      prv = hist[S+1];
      irq_n = 1'b0;
      for (int p = 0; p < NP; p++) irq_n = irq_n | (|(m_flag[p] & m_ie[p]));
      if (cs && !we) begin
        pt = int'(addr[4:3]);
        rv = 8'h00;
        if (pt < NP) begin
          case (addr[2:0])
            3'd0: rv = m_out[pt];
            3'd1: rv = m_dir[pt];
            3'd2: rv = cur[8*pt +: 8];
            3'd3: rv = m_ie[pt];
            3'd4: rv = m_edge[pt];
            3'd5: rv = m_both[pt];
            3'd6: rv = m_flag[pt];
            default: rv = 8'h00;
          endcase
        end
        m_dout = rv;
      end
      for (int p = 0; p < NP; p++) begin
        evt = 8'h00;
        for (int b = 0; b < 8; b++) begin
          a = cur[8*p + b];
          z = prv[8*p + b];
          if (a != z) begin
            if (m_both[p][b])      evt[b] = 1'b1;
            else if (m_edge[p][b]) evt[b] = !a;
            else                   evt[b] = a;
          end
        end
        if (cs && we && int'(addr[4:3]) == p && addr[2:0] == 3'd6)
          m_flag[p] = m_flag[p] & ~din;
        m_flag[p] = m_flag[p] | evt;
        if (cs && we && int'(addr[4:3]) == p) begin
          case (addr[2:0])
            3'd0: m_out[p]  = din;
            3'd1: m_dir[p]  = din;
            3'd3: m_ie[p]   = din;
            3'd4: m_edge[p] = din;
            3'd5: m_both[p] = din;
            3'd7: if (din[7]) m_out[p] = m_out[p] | {1'b0, din[6:0]};
                  else        m_out[p] = m_out[p] & ~{1'b0, din[6:0]};
            default: ;
          endcase
        end
      end
      m_irq = irq_n;
    end
    for (int p = 0; p < NP; p++) begin
      e.o[8*p +: 8]  = m_out[p];
      e.oe[8*p +: 8] = m_dir[p];
    end
    e.dout = m_dout; e.irq = m_irq; e.cyc = ncyc;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("dout",    e.cyc, 32'(dout),    32'(e.dout));
      chk("gpio_o",  e.cyc, 32'(gpio_o),  32'(e.o));
      chk("gpio_oe", e.cyc, 32'(gpio_oe), 32'(e.oe));
      chk("irq",     e.cyc, 32'(irq),     32'(e.irq));
    end
  end

  task automatic cyc(input logic r, input logic c, input logic w, input logic [4:0] a, input logic [7:0] d);
    rst_n = r; cs = c; we = w; addr = a; din = d; gpio_i = pad_v;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();             cyc(1'b1, 1'b0, 1'b0, 5'h00, 8'h00); endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d); cyc(1'b1, 1'b1, 1'b1, a, d); endtask
  task automatic rd(input logic [4:0] a); cyc(1'b1, 1'b1, 1'b0, a, $urandom()); endtask

  initial begin
    pad_v = '0;
    for (int i = 0; i < S + 2; i++) hist.push_back('0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    rd(5'h00); rd(5'h01); rd(5'h05); rd(5'h06); idle();

    // OUT / DIR / SET-CLR
    wr(5'h00, 8'hA5); wr(5'h01, 8'hF0); wr(5'h07, 8'h83); wr(5'h07, 8'h01);
    rd(5'h00); rd(5'h01); rd(5'h07);

    // rising edge with interrupt enabled, then clear
    wr(5'h03, 8'h01);
    pad_v[0] = 1'b1;
    repeat (5) idle();
    rd(5'h06); rd(5'h02);
    wr(5'h06, 8'h01); idle(); idle(); rd(5'h06);

    // both-edge pulse; clear lands exactly on the falling event
    wr(5'h05, 8'h04);
    pad_v[2] = 1'b1; idle();
    repeat (4) idle();
    pad_v[2] = 1'b0; idle();
    for (int i = 1; i < S; i++) idle();
    wr(5'h06, 8'h04);
    rd(5'h06); idle(); rd(5'h06);

    // absent port, and port 1 activity isolated from port 0
    wr(5'h10, 8'hFF); wr(5'h18, 8'hFF); rd(5'h10); rd(5'h18); rd(5'h16);
    pad_v[15:8] = 8'h3C; repeat (4) idle();
    pad_v[15:8] = 8'h00; repeat (4) idle();
    rd(5'h06); rd(5'h0E);

    // reset during a write while irq is high
    wr(5'h0B, 8'hFF); idle(); idle();
    cyc(1'b0, 1'b1, 1'b1, 5'h08, 8'hFF);
    idle(); rd(5'h08); rd(5'h0E); rd(5'h00);

    // pad held high through reset
    pad_v = {NP{8'h81}};
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    repeat (S + 3) idle();
    rd(5'h06); rd(5'h0E);

    // randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) pad_v = pad_v ^ (($urandom() & $urandom()) & {(8*NP){1'b1}});
      cyc(($urandom_range(0, 199) != 0), 1'($urandom()), 1'($urandom()), 5'($urandom()), 8'($urandom()));
    end

    idle();
    @(negedge clk); #1;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
